// File: rtl/fft16_input_loader.sv
// fft16_input_loader: collects 16 complex time-domain samples in bit-reversed
// order, then presents them as 8 stage-1 radix-2 butterfly operand pairs.
//
// Optional feature: define FFT16_LOADER_PRESCALE_EN to store every part as an
// arithmetic right shift by 4, which leaves headroom for 4 radix-2 stages.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid, i_re, i_im   input sample (accepted whenever o_ready=1)
//   o_ready               high while collecting samples (FILL)
//   o_valid               butterfly pair outputs valid (DRAIN)
//   o_out0_*, o_out1_*    operand pair buffer[2p], buffer[2p+1]
//   o_twiddle_re/_im      stage-1 twiddle factor (always W^0 = 1.0)
//   o_pair_idx, o_last    index of the presented pair, high on pair 7
module fft16_input_loader #(
    parameter int unsigned N = 16,
    parameter int unsigned Q = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic [N-1:0] i_re,
    input  logic [N-1:0] i_im,
    output logic         o_ready,
    output logic         o_valid,
    output logic [N-1:0] o_out0_re,
    output logic [N-1:0] o_out0_im,
    output logic [N-1:0] o_out1_re,
    output logic [N-1:0] o_out1_im,
    output logic [N-1:0] o_twiddle_re,
    output logic [N-1:0] o_twiddle_im,
    output logic [2:0]   o_pair_idx,
    output logic         o_last
);

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned PW    = 3;
    localparam logic [N-1:0] TW_ONE = N'(1) << Q;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pair_q, pair_d;
    logic            wr_en;

    logic [N-1:0]    buf_re [DEPTH];
    logic [N-1:0]    buf_im [DEPTH];

    logic            ready_d, valid_d, last_d;
    logic [N-1:0]    out0_re_d, out0_im_d, out1_re_d, out1_im_d;
    logic [N-1:0]    tw_re_d, tw_im_d;
    logic [PW-1:0]   idx_d;
    logic            load_pair;
    logic [PW-1:0]   sel_pair;

    function automatic logic [AW-1:0] bitrev4(input logic [AW-1:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    function automatic logic [N-1:0] store_val(input logic [N-1:0] x);
`ifdef FFT16_LOADER_PRESCALE_EN
        return N'($signed(x) >>> 4);
`else
        return x;
`endif
    endfunction

    // Next-state, counters and next output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pair_d    = pair_q;
        wr_en     = 1'b0;
        load_pair = 1'b0;
        sel_pair  = '0;
        ready_d   = 1'b1;
        valid_d   = 1'b0;
        out0_re_d = '0;
        out0_im_d = '0;
        out1_re_d = '0;
        out1_im_d = '0;
        tw_re_d   = '0;
        tw_im_d   = '0;
        idx_d     = '0;
        last_d    = 1'b0;

        case (state_q)
            FILL: begin
                if (i_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        // Pair 0 reads addresses 0/1, never the one written by k=15.
                        state_d   = DRAIN;
                        cnt_d     = '0;
                        pair_d    = '0;
                        load_pair = 1'b1;
                        sel_pair  = '0;
                        ready_d   = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (pair_q == PW'(7)) begin
                    state_d = FILL;
                    pair_d  = '0;
                    cnt_d   = '0;
                end else begin
                    pair_d    = pair_q + PW'(1);
                    load_pair = 1'b1;
                    sel_pair  = pair_q + PW'(1);
                    ready_d   = 1'b0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        if (load_pair) begin
            valid_d   = 1'b1;
            out0_re_d = buf_re[{sel_pair, 1'b0}];
            out0_im_d = buf_im[{sel_pair, 1'b0}];
            out1_re_d = buf_re[{sel_pair, 1'b1}];
            out1_im_d = buf_im[{sel_pair, 1'b1}];
            tw_re_d   = TW_ONE;
            tw_im_d   = '0;
            idx_d     = sel_pair;
            last_d    = (sel_pair == PW'(7));
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            pair_q       <= '0;
            o_ready      <= 1'b1;
            o_valid      <= 1'b0;
            o_out0_re    <= '0;
            o_out0_im    <= '0;
            o_out1_re    <= '0;
            o_out1_im    <= '0;
            o_twiddle_re <= '0;
            o_twiddle_im <= '0;
            o_pair_idx   <= '0;
            o_last       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pair_q       <= pair_d;
            o_ready      <= ready_d;
            o_valid      <= valid_d;
            o_out0_re    <= out0_re_d;
            o_out0_im    <= out0_im_d;
            o_out1_re    <= out1_re_d;
            o_out1_im    <= out1_im_d;
            o_twiddle_re <= tw_re_d;
            o_twiddle_im <= tw_im_d;
            o_pair_idx   <= idx_d;
            o_last       <= last_d;
        end
    end

    // Sample buffer, bit-reversed write address; contents are not reset.
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_rst) begin
            buf_re[bitrev4(cnt_q)] <= store_val(i_re);
            buf_im[bitrev4(cnt_q)] <= store_val(i_im);
        end
    end

endmodule

// File: tb/tb_fft16_input_loader.sv
// Self-checking bench for fft16_input_loader (N=16, Q=8).
// Reference: sample k lands at position bitrev(k); pair p is positions 2p/2p+1.
module tb_fft16_input_loader;

    logic        clk = 1'b0;
    logic        i_rst, i_valid;
    logic [15:0] i_re, i_im;
    logic        o_ready, o_valid, o_last;
    logic [15:0] o_out0_re, o_out0_im, o_out1_re, o_out1_im;
    logic [15:0] o_twiddle_re, o_twiddle_im;
    logic [2:0]  o_pair_idx;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] f_re [16];
    logic [15:0] f_im [16];
    logic [15:0] m_re [16];
    logic [15:0] m_im [16];

    always #5 clk = ~clk;

    fft16_input_loader #(.N(16), .Q(8)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_re         (i_re),
        .i_im         (i_im),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .o_out0_re    (o_out0_re),
        .o_out0_im    (o_out0_im),
        .o_out1_re    (o_out1_re),
        .o_out1_im    (o_out1_im),
        .o_twiddle_re (o_twiddle_re),
        .o_twiddle_im (o_twiddle_im),
        .o_pair_idx   (o_pair_idx),
        .o_last       (o_last)
    );

    function automatic logic [3:0] brev(input int k);
        logic [3:0] x;
        x = 4'(k);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    function automatic logic [15:0] stored(input logic [15:0] x);
`ifdef FFT16_LOADER_PRESCALE_EN
        return 16'($signed(x) >>> 4);
`else
        return x;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'(0));
        chk({tag, "_ready"}, 32'(o_ready), 32'(1));
        chk({tag, "_data"}, {o_out0_re | o_out0_im | o_out1_re | o_out1_im,
                             o_twiddle_re | o_twiddle_im}, 32'(0));
        chk({tag, "_idx"}, 32'(o_pair_idx), 32'(0));
        chk({tag, "_last"}, 32'(o_last), 32'(0));
    endtask

    // Feed f_re/f_im as one frame; optional idle cycle before each sample.
    task automatic fill(input bit gap);
        for (int k = 0; k < 16; k++) begin
            if (gap) begin
                i_valid = 1'b0;
                i_re    = 16'($urandom);
                i_im    = 16'($urandom);
                tick();
                chk("gap_valid", 32'(o_valid), 32'(0));
                chk("gap_ready", 32'(o_ready), 32'(1));
            end
            i_valid = 1'b1;
            i_re    = f_re[k];
            i_im    = f_im[k];
            tick();
            m_re[brev(k)] = stored(f_re[k]);
            m_im[brev(k)] = stored(f_im[k]);
            if (k < 15) begin
                chk("fill_valid", 32'(o_valid), 32'(0));
                chk("fill_ready", 32'(o_ready), 32'(1));
            end
        end
    endtask

    // Check the 8 drain pairs; optionally keep i_valid high or reset at a pair.
    task automatic drain(input bit hold, input int abort_at);
        i_valid = hold;
        i_re    = 16'($urandom);
        i_im    = 16'($urandom);
        for (int p = 0; p < 8; p++) begin
            chk("drn_valid", 32'(o_valid), 32'(1));
            chk("drn_ready", 32'(o_ready), 32'(0));
            chk("drn_idx", 32'(o_pair_idx), 32'(p));
            chk("drn_last", 32'(o_last), 32'(p == 7));
            chk("drn_out0", {o_out0_re, o_out0_im}, {m_re[2*p], m_im[2*p]});
            chk("drn_out1", {o_out1_re, o_out1_im}, {m_re[2*p+1], m_im[2*p+1]});
            chk("drn_tw", {o_twiddle_re, o_twiddle_im}, {16'h0100, 16'h0000});
            if (p == abort_at) begin
                i_rst = 1'b1;
                tick();
                i_rst   = 1'b0;
                i_valid = 1'b0;
                check_idle("rst_drain");
                return;
            end
            tick();
            i_re = 16'($urandom);
            i_im = 16'($urandom);
        end
        check_idle("post_drain");
        i_valid = 1'b0;
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 16; k++) begin
            f_re[k] = 16'($urandom);
            f_im[k] = 16'($urandom);
        end
    endtask

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_re    = 16'h1234;
        i_im    = 16'h5678;
        tick();
        tick();
        check_idle("reset");
        i_rst   = 1'b0;
        i_valid = 1'b0;

        // Ramp frame: re = k*256, im = 0.
        for (int k = 0; k < 16; k++) begin
            f_re[k] = 16'(k * 256);
            f_im[k] = 16'h0000;
        end
        fill(1'b0);
        chk("ramp_p0", {o_out0_re, o_out1_re}, {stored(16'h0000), stored(16'h0800)});
        drain(1'b0, 8);

        // Same ramp with gapped valid.
        fill(1'b1);
        drain(1'b0, 8);

        // Valid held high through drain; next frame must start at its own k=0.
        rand_frame();
        fill(1'b0);
        drain(1'b1, 8);
        rand_frame();
        fill(1'b0);
        drain(1'b0, 8);

        // Reset on pair 3, then a fresh frame.
        rand_frame();
        fill(1'b0);
        drain(1'b0, 3);
        rand_frame();
        fill(1'b0);
        drain(1'b0, 8);

        // Reset mid-fill (together with i_valid) discards the partial frame.
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_re    = 16'($urandom);
            i_im    = 16'($urandom);
            tick();
        end
        i_rst = 1'b1;
        tick();
        i_rst   = 1'b0;
        i_valid = 1'b0;
        check_idle("rst_fill");
        rand_frame();
        fill(1'b0);
        drain(1'b0, 8);

        // Back-to-back frames with distinct data.
        rand_frame();
        fill(1'b0);
        drain(1'b0, 8);
        for (int k = 0; k < 16; k++) begin
            f_re[k] = f_re[k] + 16'h1111;
            f_im[k] = f_im[k] ^ 16'h8421;
        end
        fill(1'b0);
        drain(1'b0, 8);

        // Sign handling: first half 0x0800, second half 0xF000.
        for (int k = 0; k < 16; k++) begin
            f_re[k] = (k < 8) ? 16'h0800 : 16'hF000;
            f_im[k] = (k < 8) ? 16'hF000 : 16'h0800;
        end
        fill(1'b0);
`ifdef FFT16_LOADER_PRESCALE_EN
        chk("prescale_re", {o_out0_re, o_out1_re}, {16'h0080, 16'hFF00});
        chk("prescale_im", {o_out0_im, o_out1_im}, {16'hFF00, 16'h0080});
`else
        chk("raw_re", {o_out0_re, o_out1_re}, {16'h0800, 16'hF000});
        chk("raw_im", {o_out0_im, o_out1_im}, {16'hF000, 16'h0800});
`endif
        drain(1'b0, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
